reg_bank_n: RTL and testbench
=============================

# reg_bank_n

Parametrised, instruction-driven register bank: the successor to the fixed 8×8-bit bank. Width and depth are parameters; the register index is carried as an instruction field, not encoded per-register in the opcode. The block adds register-to-register move, single and bulk clear, optional increment/decrement, and an explicit error flag. It sits on the shared instruction bus, like the other instruction-controlled peripherals, and drives one selected register onto `out`.

## Interface
- `DATA_WIDTH`, 8: register and immediate width, 1..32.
- `REG_COUNT`, 8: number of registers; power of two, 2..16. `IDX_WIDTH = clog2(REG_COUNT)`.
- `clock`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `inst`  in  4+IDX_WIDTH+DATA_WIDTH  instruction fields:
  - `[top:top-3]` opcode
  - next `IDX_WIDTH` bits: register index `idx`
  - low `DATA_WIDTH` bits: immediate `imm`
- `inst_en`  in  1  `inst` is valid this cycle.
- `out`  out  DATA_WIDTH  value of the register selected by `out_sel`.
- `error`  out  1  high while in Error state.

## Operation
- States: Reset, Ready, Error.
- Reset → Ready unconditionally after one cycle.
- Ready → Error on an illegal opcode with `inst_en`=1.
- Error is sticky until `reset`.
- `reset`, Reset state and Error state all force:
  - every register to 0
  - `out_sel` to 0
- Reset state ignores `inst_en`; an instruction presented there is dropped silently.
- Ready with `inst_en`=0: all state held.
- Opcodes, executed in Ready with `inst_en`=1:
  - 0 NOP: no change.
  - 1 RDO: `out_sel <= idx`.
  - 2 LDI: `reg[idx] <= imm`.
  - 3 MOV: `reg[idx] <= reg[imm[IDX_WIDTH-1:0]]`; the upper `imm` bits are ignored. MOV with source = destination is a no-op.
  - 4 CLR: `reg[idx] <= 0`.
  - 5 CLA: all registers ← 0; `out_sel` unchanged.
  - 6 INC: `reg[idx] <= reg[idx]+1`, modulo 2^DATA_WIDTH; all-ones wraps to 0. Present only with the macro below.
  - 7 DEC: `reg[idx] <= reg[idx]-1`, modulo 2^DATA_WIDTH; 0 wraps to all-ones. Present only with the macro below.
  - 8–15: illegal → Error. All registers and `out_sel` are cleared on the transition edge.
- Index bits beyond `IDX_WIDTH` do not exist. Every `idx` value is legal.
- Only one instruction is accepted per cycle. No backpressure: every `inst_en` cycle in Ready is consumed.

## Timing
- `out` is combinational from `out_sel` and the register array. No registered output stage.
- Latency: an instruction accepted at edge N is visible on `out` after edge N.
  - RDO: the new selection appears on `out` after edge N.
  - A write to the selected register: the new value appears on `out` after edge N.
- Back-to-back dependent instructions need no bubbles, because operands are read from current state. Example: LDI r2 then INC r2 on consecutive cycles gives imm+1.
- `error` rises the cycle after the illegal instruction's edge and stays high.
- Reset values: `out`=0, `error`=0. After `reset` falls, the first cycle is Reset state; instructions are accepted from the second cycle.
- `reset` asserted mid-stream overrides any concurrent `inst_en`.

## Configuration
- `REG_BANK_N_ARITH_EN`:
  - Defined: INC/DEC are implemented as above.
  - Undefined: opcodes 6 and 7 are illegal and drive the block to Error. No adder/subtractor logic is generated.

## Structure
- Package `reg_bank_n_pkg` holds:
  - opcode constants (NOP..DEC)
  - state encodings (Reset=0, Ready=1, Error=2)
  - field-extraction width helpers
- One sub-module, `reg_bank_n_decode`, combinational.
  - Inputs: opcode, `inst_en`, state.
  - Outputs: one-hot operation strobes plus the illegal flag.
- The register array, `out_sel` and the state machine stay in the top module.

## Test plan
- Reset then LDI r0..r7 with 0x10..0x17, RDO 5 → `out`=0x15 one cycle after RDO, `error`=0.
- LDI r3=0xA5, MOV r6←r3, RDO 6 → `out`=0xA5; r3 still 0xA5 after RDO 3.
- With ARITH: LDI r1=0xFF, INC r1 → r1=0x00. Then DEC r1 twice → r1=0xFE. Run with no idle cycles between instructions.
- Without ARITH: opcode 6 → `error`=1 next cycle, `out`=0. Subsequent LDI is ignored until `reset`.
- Opcode 0xF with `inst_en`=0 → no effect. Opcode 0xF with `inst_en`=1 → Error. Then `reset` → `error`=0, `out`=0, and LDI is accepted again from the second post-reset cycle.
- DATA_WIDTH=12, REG_COUNT=16: LDI r15=0xABC, RDO 15 → `out`=0xABC. CLA → `out`=0 with `out_sel` still 15.

Source files
------------

// File: rtl/reg_bank_n_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_n_pkg
// Purpose  : Shared constants and types for the parametrised register bank:
//            opcode values, state encodings and instruction field width
//            helpers.
// Ports    : none (package)
// Config   : REG_BANK_N_ARITH_EN enables the INC/DEC opcodes (see decoder)
// Revision : 1.0  initial release
// ============================================================================
package reg_bank_n_pkg;

   // Instruction opcode field width and opcode values
   localparam int         c_opcode_width = 4;
   localparam logic [3:0] c_op_nop = 4'd0;
   localparam logic [3:0] c_op_rdo = 4'd1;
   localparam logic [3:0] c_op_ldi = 4'd2;
   localparam logic [3:0] c_op_mov = 4'd3;
   localparam logic [3:0] c_op_clr = 4'd4;
   localparam logic [3:0] c_op_cla = 4'd5;
   localparam logic [3:0] c_op_inc = 4'd6;
   localparam logic [3:0] c_op_dec = 4'd7;

   // Controller states
   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_READY = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   // Width of the register index field
   function automatic int idx_width(input int reg_count);
      return $clog2(reg_count);
   endfunction

   // Total instruction width: opcode + index + immediate
   function automatic int inst_width(input int data_width, input int reg_count);
      return c_opcode_width + idx_width(reg_count) + data_width;
   endfunction

   // Smaller of two widths; used where a narrow immediate feeds an index
   function automatic int min_width(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

endpackage : reg_bank_n_pkg
`default_nettype wire

// File: rtl/reg_bank_n_decode.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_n_decode
// Purpose  : Combinational opcode decoder. Produces one-hot operation strobes
//            that are only asserted for an instruction accepted in the Ready
//            state, plus an illegal-opcode flag.
// Ports    : opcode   in   4-bit opcode field
//            inst_en  in   instruction valid
//            state    in   controller state
//            op_*     out  operation strobes (one-hot)
//            illegal  out  accepted instruction carries an illegal opcode
// Config   : REG_BANK_N_ARITH_EN defined  -> opcodes 6/7 decode to INC/DEC
//            REG_BANK_N_ARITH_EN undefined -> opcodes 6/7 are illegal
// Revision : 1.0  initial release
// ============================================================================
module reg_bank_n_decode
   import reg_bank_n_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic       inst_en,
   input  state_t     state,
   output logic       op_rdo,
   output logic       op_ldi,
   output logic       op_mov,
   output logic       op_clr,
   output logic       op_cla,
`ifdef REG_BANK_N_ARITH_EN
   output logic       op_inc,
   output logic       op_dec,
`endif
   output logic       illegal
);

   logic w_accept;

   // Instructions are only consumed in Ready; Reset and Error drop them.
   assign w_accept = inst_en && (state == ST_READY);

   always_comb begin
      op_rdo  = 1'b0;
      op_ldi  = 1'b0;
      op_mov  = 1'b0;
      op_clr  = 1'b0;
      op_cla  = 1'b0;
`ifdef REG_BANK_N_ARITH_EN
      op_inc  = 1'b0;
      op_dec  = 1'b0;
`endif
      illegal = 1'b0;
      if (w_accept) begin
         case (opcode)
            c_op_nop: ;
            c_op_rdo: op_rdo = 1'b1;
            c_op_ldi: op_ldi = 1'b1;
            c_op_mov: op_mov = 1'b1;
            c_op_clr: op_clr = 1'b1;
            c_op_cla: op_cla = 1'b1;
`ifdef REG_BANK_N_ARITH_EN
            c_op_inc: op_inc = 1'b1;
            c_op_dec: op_dec = 1'b1;
`endif
            default:  illegal = 1'b1;
         endcase
      end
   end

endmodule : reg_bank_n_decode
`default_nettype wire

// File: rtl/reg_bank_n.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_n
// Purpose  : Parametrised instruction-driven register bank. Executes one
//            instruction per cycle from the shared instruction bus and drives
//            the register selected by an internal output selector onto out.
// Ports    : clock    in   clock, rising edge
//            reset    in   synchronous active-high reset
//            inst     in   {opcode[3:0], idx[IDX_WIDTH-1:0], imm[DATA_WIDTH-1:0]}
//            inst_en  in   inst valid this cycle
//            out      out  value of the selected register (combinational)
//            error    out  high while in the Error state
// Config   : REG_BANK_N_ARITH_EN enables INC/DEC; otherwise they are illegal
//            and no adder/subtractor is built.
// Revision : 1.0  initial release
// ============================================================================
module reg_bank_n
   import reg_bank_n_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int REG_COUNT  = 8
)(
   input  logic                                         clock,
   input  logic                                         reset,
   input  logic [inst_width(DATA_WIDTH, REG_COUNT)-1:0] inst,
   input  logic                                         inst_en,
   output logic [DATA_WIDTH-1:0]                        out,
   output logic                                         error
);

   localparam int IDX_WIDTH  = idx_width(REG_COUNT);
   localparam int INST_WIDTH = inst_width(DATA_WIDTH, REG_COUNT);
   // Immediate bits that can reach the MOV source index (DATA_WIDTH may be
   // narrower than the index).
   localparam int SRC_WIDTH  = min_width(IDX_WIDTH, DATA_WIDTH);

   state_t                r_state;
   state_t                w_state_next;
   logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
   logic [IDX_WIDTH-1:0]  r_out_sel;

   logic [3:0]            w_opcode;
   logic [IDX_WIDTH-1:0]  w_idx;
   logic [DATA_WIDTH-1:0] w_imm;
   logic [IDX_WIDTH-1:0]  w_src;

   logic w_op_rdo;
   logic w_op_ldi;
   logic w_op_mov;
   logic w_op_clr;
   logic w_op_cla;
   logic w_illegal;

   assign w_opcode = inst[INST_WIDTH-1 -: 4];
   assign w_idx    = inst[DATA_WIDTH +: IDX_WIDTH];
   assign w_imm    = inst[DATA_WIDTH-1:0];
   // MOV source: low immediate bits only, upper bits ignored
   assign w_src    = IDX_WIDTH'(w_imm[SRC_WIDTH-1:0]);

`ifdef REG_BANK_N_ARITH_EN
   logic                  w_op_inc;
   logic                  w_op_dec;
   logic [DATA_WIDTH-1:0] w_inc_val;
   logic [DATA_WIDTH-1:0] w_dec_val;

   // Natural modulo-2^DATA_WIDTH wrap gives all-ones+1=0 and 0-1=all-ones.
   assign w_inc_val = r_regs[w_idx] + DATA_WIDTH'(1);
   assign w_dec_val = r_regs[w_idx] - DATA_WIDTH'(1);
`endif

   reg_bank_n_decode u_decode (
      .opcode  (w_opcode),
      .inst_en (inst_en),
      .state   (r_state),
      .op_rdo  (w_op_rdo),
      .op_ldi  (w_op_ldi),
      .op_mov  (w_op_mov),
      .op_clr  (w_op_clr),
      .op_cla  (w_op_cla),
`ifdef REG_BANK_N_ARITH_EN
      .op_inc  (w_op_inc),
      .op_dec  (w_op_dec),
`endif
      .illegal (w_illegal)
   );

   // ------------------------------------------------------------------------
   // State machine
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_RESET;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_RESET: w_state_next = ST_READY;
         ST_READY: if (w_illegal) w_state_next = ST_ERROR;
         ST_ERROR: w_state_next = ST_ERROR;
         default:  w_state_next = ST_RESET;
      endcase
   end

   // ------------------------------------------------------------------------
   // Register array and output selector
   // ------------------------------------------------------------------------
   // Outside Ready (and on the edge that enters Error) everything is held
   // cleared. Operands are read from current state, so dependent
   // back-to-back instructions need no bubbles.
   always_ff @(posedge clock) begin
      if (reset || (r_state != ST_READY) || w_illegal) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            r_regs[i] <= '0;
         end
         r_out_sel <= '0;
      end else begin
         if (w_op_rdo) begin
            r_out_sel <= w_idx;
         end
         if (w_op_cla) begin
            for (int i = 0; i < REG_COUNT; i++) begin
               r_regs[i] <= '0;
            end
         end else if (w_op_ldi) begin
            r_regs[w_idx] <= w_imm;
         end else if (w_op_mov) begin
            r_regs[w_idx] <= r_regs[w_src];
         end else if (w_op_clr) begin
            r_regs[w_idx] <= '0;
`ifdef REG_BANK_N_ARITH_EN
         end else if (w_op_inc) begin
            r_regs[w_idx] <= w_inc_val;
         end else if (w_op_dec) begin
            r_regs[w_idx] <= w_dec_val;
`endif
         end
      end
   end

   assign out   = r_regs[r_out_sel];
   assign error = (r_state == ST_ERROR);

endmodule : reg_bank_n
`default_nettype wire

// File: tb/tb_reg_bank_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_n
// Purpose  : Self-checking bench for reg_bank_n. Drives two instances
//            (8x8 default and 16x12) from a vector table; each applied vector
//            pushes its expected out/error into a scoreboard queue that is
//            popped and compared after the clock edge.
// Config   : REG_BANK_N_ARITH_EN selects the INC/DEC expectations
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_bank_n;

   localparam logic [3:0] NOP = 4'd0;
   localparam logic [3:0] RDO = 4'd1;
   localparam logic [3:0] LDI = 4'd2;
   localparam logic [3:0] MOV = 4'd3;
   localparam logic [3:0] CLR = 4'd4;
   localparam logic [3:0] CLA = 4'd5;
   localparam logic [3:0] INC = 4'd6;
   localparam logic [3:0] DEC = 4'd7;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [14:0] inst_a = '0;
   logic        en_a = 1'b0;
   logic [7:0]  out_a;
   logic        err_a;
   logic [19:0] inst_b = '0;
   logic        en_b = 1'b0;
   logic [11:0] out_b;
   logic        err_b;

   reg_bank_n #(.DATA_WIDTH(8), .REG_COUNT(8)) dut_a (
      .clock   (clock),
      .reset   (reset),
      .inst    (inst_a),
      .inst_en (en_a),
      .out     (out_a),
      .error   (err_a)
   );

   reg_bank_n #(.DATA_WIDTH(12), .REG_COUNT(16)) dut_b (
      .clock   (clock),
      .reset   (reset),
      .inst    (inst_b),
      .inst_en (en_b),
      .out     (out_b),
      .error   (err_b)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit          rst;
      bit          b;
      logic [3:0]  op;
      int          idx;
      logic [11:0] imm;
      bit          en;
      logic [11:0] exp_out;
      bit          exp_err;
   } vec_t;

   typedef struct {
      int          id;
      bit          b;
      logic [11:0] exp_out;
      bit          exp_err;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic v(input bit rst, input bit b, input logic [3:0] op, input int idx,
                    input logic [11:0] imm, input bit en, input logic [11:0] eo,
                    input bit ee);
      vec_t t;
      t.rst = rst; t.b = b; t.op = op; t.idx = idx; t.imm = imm;
      t.en = en; t.exp_out = eo; t.exp_err = ee;
      vecs.push_back(t);
   endtask

   initial begin
      // ---- reset behaviour and Reset-state drop ----
      v(1, 0, NOP, 0, 12'h000, 0, 12'h000, 0);
      v(1, 0, LDI, 0, 12'h099, 1, 12'h000, 0);   // reset beats inst_en
      v(0, 0, LDI, 0, 12'h099, 1, 12'h000, 0);   // Reset state drops it
      // ---- load r0..r7, read r5 ----
      for (int i = 0; i < 8; i++) v(0, 0, LDI, i, 12'h010 + 12'(i), 1, 12'h010, 0);
      v(0, 0, RDO, 5, 12'h000, 1, 12'h015, 0);
      v(0, 0, NOP, 2, 12'h0FF, 1, 12'h015, 0);
      v(0, 0, LDI, 5, 12'h0EE, 0, 12'h015, 0);   // inst_en low: held
      v(0, 0, 4'hF, 0, 12'h000, 0, 12'h015, 0);  // illegal but not valid
      // ---- MOV, CLR, CLA ----
      v(0, 0, LDI, 3, 12'h0A5, 1, 12'h015, 0);
      v(0, 0, MOV, 6, 12'h0F3, 1, 12'h015, 0);   // upper imm bits ignored
      v(0, 0, RDO, 6, 12'h000, 1, 12'h0A5, 0);
      v(0, 0, RDO, 3, 12'h000, 1, 12'h0A5, 0);
      v(0, 0, MOV, 3, 12'h003, 1, 12'h0A5, 0);   // self move
      v(0, 0, LDI, 3, 12'h03C, 1, 12'h03C, 0);
      v(0, 0, CLR, 3, 12'h000, 1, 12'h000, 0);
      v(0, 0, RDO, 6, 12'h000, 1, 12'h0A5, 0);
      v(0, 0, CLA, 2, 12'h000, 1, 12'h000, 0);
      v(0, 0, RDO, 5, 12'h000, 1, 12'h000, 0);
      v(0, 0, LDI, 5, 12'h077, 1, 12'h077, 0);   // selection survived CLA
      v(0, 0, RDO, 1, 12'h000, 1, 12'h000, 0);
`ifdef REG_BANK_N_ARITH_EN
      v(0, 0, LDI, 1, 12'h0FF, 1, 12'h0FF, 0);
      v(0, 0, INC, 1, 12'h000, 1, 12'h000, 0);
      v(0, 0, DEC, 1, 12'h000, 1, 12'h0FF, 0);
      v(0, 0, DEC, 1, 12'h000, 1, 12'h0FE, 0);
      v(0, 0, INC, 2, 12'h000, 1, 12'h0FE, 0);
      v(0, 0, RDO, 2, 12'h000, 1, 12'h001, 0);
`else
      v(0, 0, LDI, 1, 12'h0FF, 1, 12'h0FF, 0);
      v(0, 0, INC, 1, 12'h000, 1, 12'h000, 1);   // illegal without arith
      v(0, 0, LDI, 0, 12'h055, 1, 12'h000, 1);   // ignored in Error
      v(0, 0, RDO, 0, 12'h000, 1, 12'h000, 1);
`endif
      // ---- illegal opcode, sticky error, recovery via reset ----
      v(1, 0, LDI, 0, 12'h042, 1, 12'h000, 0);
      v(0, 0, LDI, 0, 12'h042, 1, 12'h000, 0);
      v(0, 0, LDI, 0, 12'h042, 1, 12'h042, 0);
      v(0, 0, 4'hF, 0, 12'h000, 0, 12'h042, 0);
      v(0, 0, 4'hF, 0, 12'h000, 1, 12'h000, 1);
      v(0, 0, LDI, 0, 12'h011, 1, 12'h000, 1);
      v(0, 0, NOP, 0, 12'h000, 0, 12'h000, 1);
      v(1, 0, NOP, 0, 12'h000, 0, 12'h000, 0);
      v(0, 0, NOP, 0, 12'h000, 0, 12'h000, 0);
      v(0, 0, LDI, 0, 12'h011, 1, 12'h011, 0);
      v(0, 0, 4'h8, 0, 12'h000, 1, 12'h000, 1);
`ifndef REG_BANK_N_ARITH_EN
      v(1, 0, NOP, 0, 12'h000, 0, 12'h000, 0);
      v(0, 0, NOP, 0, 12'h000, 0, 12'h000, 0);
      v(0, 0, LDI, 0, 12'h005, 1, 12'h005, 0);
      v(0, 0, DEC, 0, 12'h000, 1, 12'h000, 1);
`endif
      // ---- 12-bit x 16 instance ----
      v(1, 1, NOP, 0, 12'h000, 0, 12'h000, 0);
      v(0, 1, NOP, 0, 12'h000, 0, 12'h000, 0);
      v(0, 1, LDI, 15, 12'hABC, 1, 12'h000, 0);
      v(0, 1, RDO, 15, 12'h000, 1, 12'hABC, 0);
      v(0, 1, CLA, 0, 12'h000, 1, 12'h000, 0);
      v(0, 1, LDI, 15, 12'h123, 1, 12'h123, 0);  // out_sel still 15
      v(0, 1, MOV, 7, 12'hFFF, 1, 12'h123, 0);
      v(0, 1, RDO, 7, 12'h000, 1, 12'h123, 0);
      v(0, 1, LDI, 0, 12'h456, 1, 12'h123, 0);
      v(0, 1, RDO, 0, 12'h000, 1, 12'h456, 0);

      // ---- apply ----
      for (int i = 0; i < vecs.size(); i++) begin
         vec_t        t;
         exp_t        e;
         logic [3:0]  ix;
         logic [11:0] act_out;
         bit          act_err;
         t  = vecs[i];
         ix = t.idx[3:0];
         @(negedge clock);
         reset  = t.rst;
         en_a   = t.en && !t.b;
         en_b   = t.en && t.b;
         inst_a = {t.op, ix[2:0], t.imm[7:0]};
         inst_b = {t.op, ix, t.imm};
         e.id = i; e.b = t.b; e.exp_out = t.exp_out; e.exp_err = t.exp_err;
         sb.push_back(e);
         @(posedge clock);
         #1;
         e = sb.pop_front();
         act_out = e.b ? out_b : {4'b0, out_a};
         act_err = e.b ? err_b : err_a;
         n_tests++;
         if (act_out !== e.exp_out) begin
            n_fail++;
            $display("FAIL vec%0d out: got %h expected %h", e.id, act_out, e.exp_out);
         end
         n_tests++;
         if (act_err !== e.exp_err) begin
            n_fail++;
            $display("FAIL vec%0d error: got %b expected %b", e.id, act_err, e.exp_err);
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_reg_bank_n
`default_nettype wire
